// File: rtl/det_seq_ctrl.sv
// Stimulus sequencer and self-checker for the 4-bit-code sequence detector.
// Optional macro SEQ_ERR_HALT_EN: the first mismatch ends the run early.
module det_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int HOLD  = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [3:0]    prog_din,
  input  logic [1:0]    prog_exp,
  input  logic [AW:0]   len,
  input  logic          start,
  input  logic [7:0]    det_q,
  output logic [3:0]    det_din,
  output logic          det_srst,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_idx
);

  localparam int HW = $clog2(HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  if (HOLD < 4) begin : g_bad_hold
    $error("det_seq_ctrl: HOLD must be at least 4");
  end

  typedef enum logic [1:0] {IDLE, FLUSH, DRIVE, FIN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    fcnt_q, fcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_idx_q, err_idx_d;
  logic [3:0]    det_din_q, det_din_d;
  logic          det_srst_q, det_srst_d;

  logic [5:0]    mem [DEPTH];
  logic          mem_we;
  logic [5:0]    cur_entry;
  logic [7:0]    exp_val;
  logic          exp_rsvd;
  logic          mismatch;

  // Program RAM holds {din, exp}; deliberately not cleared by srst.
  always_ff @(posedge clk) begin
    if (mem_we && !srst) begin
      mem[prog_addr] <= {prog_din, prog_exp};
    end
  end

  assign cur_entry = mem[idx_q];

  always_comb begin
    exp_val  = 8'h00;
    exp_rsvd = 1'b0;
    case (cur_entry[1:0])
      2'b00:   exp_val = 8'h00;
      2'b01:   exp_val = 8'h55;
      2'b10:   exp_val = 8'hFF;
      default: exp_rsvd = 1'b1;
    endcase
    mismatch = exp_rsvd || (det_q != exp_val);
  end

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    hcnt_d     = hcnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    mem_we     = 1'b0;
    det_din_d  = 4'h0;
    det_srst_d = 1'b0;

    case (state_q)
      IDLE: begin
        mem_we = prog_we;
        if (start) begin
          len_d     = (len > DEPTH_L) ? DEPTH_L : len;
          err_d     = 1'b0;
          err_idx_d = '0;
          fcnt_d    = 2'd0;
          state_d   = FLUSH;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q + 2'd1;
        if (fcnt_q == 2'd2) begin
          fcnt_d  = 2'd0;
          hcnt_d  = '0;
          idx_d   = '0;
          state_d = (len_q == '0) ? FIN : DRIVE;
        end
      end
      DRIVE: begin
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_q == HOLD_LAST) begin
          hcnt_d = '0;
          if (mismatch && !err_q) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end
          if ({1'b0, idx_q} == len_q - 1'b1) begin
            state_d = FIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
`ifdef SEQ_ERR_HALT_EN
          if (mismatch) begin
            state_d = FIN;
          end
`endif
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    det_srst_d = (state_d == FLUSH);
    if (state_d == DRIVE) begin
      det_din_d = mem[idx_d][5:2];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= IDLE;
      fcnt_q     <= 2'd0;
      hcnt_q     <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      det_din_q  <= 4'h0;
      det_srst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      hcnt_q     <= hcnt_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      det_din_q  <= det_din_d;
      det_srst_q <= det_srst_d;
    end
  end

  assign det_din  = det_din_q;
  assign det_srst = det_srst_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign err      = err_q;
  assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_det_seq_ctrl.sv
// Bench for det_seq_ctrl: a behavioural detector model plus a table of directed
// runs and hand-written sequences for the multi-cycle corner cases.
module tb_det_seq_ctrl;

  logic       clk = 1'b0;
  logic       srst;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [3:0] prog_din;
  logic [1:0] prog_exp;
  logic [3:0] len;
  logic       start;
  logic [7:0] det_q;
  logic [3:0] det_din;
  logic       det_srst;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] err_idx;

  int errors = 0;
  int checks = 0;

  logic [3:0] tr_din  [256];
  logic       tr_srst [256];
  logic       tr_busy [256];
  logic       post_busy;
  logic [3:0] post_din;

  always #5 clk = ~clk;

  det_seq_ctrl #(.DEPTH(8), .HOLD(4)) dut (
    .clk(clk), .srst(srst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_din(prog_din), .prog_exp(prog_exp), .len(len), .start(start),
    .det_q(det_q), .det_din(det_din), .det_srst(det_srst), .busy(busy),
    .done(done), .err(err), .err_idx(err_idx)
  );

  // Detector model: 2-stage synchronizer then state update, so q follows din 3 edges later.
  logic [3:0] s1, s2;
  logic [1:0] st;
  always_ff @(posedge clk) begin
    if (det_srst) begin
      s1 <= 4'h0;
      s2 <= 4'h0;
      st <= 2'b00;
    end else begin
      s1 <= det_din;
      s2 <= s1;
      case (s2)
        4'h1: st <= 2'b01;
        4'h2: st <= 2'b10;
        4'h4: st <= 2'b01;
        4'h8: st <= 2'b00;
        default: ;
      endcase
    end
  end
  assign det_q = (st == 2'b01) ? 8'h55 : (st == 2'b10) ? 8'hFF : 8'h00;

  typedef struct {
    string       name;
    logic [31:0] dins;
    logic [15:0] exps;
    logic [3:0]  l;
    int          cycles;
    logic        e;
    logic [2:0]  idx;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic program_ram(input logic [31:0] dins, input logic [15:0] exps);
    for (int i = 0; i < 8; i++) begin
      prog_we   = 1'b1;
      prog_addr = 3'(i);
      prog_din  = dins[4*i +: 4];
      prog_exp  = exps[2*i +: 2];
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  // Starts a run and counts cycles to done; optionally pokes start/prog_we mid-run,
  // and always raises start in the done cycle, which must be ignored.
  task automatic applyStimulus(input logic [3:0] l, input int poke, output int cyc);
    len   = l;
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 200) begin
      start     = (cyc == poke);
      prog_we   = (cyc == poke);
      prog_addr = 3'd0;
      prog_din  = 4'h8;
      prog_exp  = 2'b11;
      tr_din[cyc]  = det_din;
      tr_srst[cyc] = det_srst;
      tr_busy[cyc] = busy;
      @(negedge clk);
      cyc++;
    end
    prog_we = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    post_busy = busy;
    post_din  = det_din;
  endtask

  task automatic check_trace(input string tag);
    logic [31:0] d;
    logic [3:0]  exp_din;
    d = 32'h8421_8421;
    checkOutput({tag, " busy after start"}, 32'(tr_busy[1]), 32'd1);
    for (int c = 1; c < 20; c++) begin
      exp_din = (c >= 4) ? d[4*((c-4)/4) +: 4] : 4'h0;
      checkOutput($sformatf("%s det_srst c%0d", tag, c), 32'(tr_srst[c]), 32'(c <= 3));
      checkOutput($sformatf("%s det_din c%0d", tag, c), 32'(tr_din[c]), 32'(exp_din));
    end
  endtask

  initial begin
    int cyc;
    int exp_cyc;

    vecs[0] = '{"clean",     32'h8421_8421, 16'h1919, 4'd4,  20, 1'b0, 3'd0};
    vecs[1] = '{"mismatch1", 32'h8421_8421, 16'h1915, 4'd4,  20, 1'b1, 3'd1};
    vecs[2] = '{"ignored",   32'h8421_8231, 16'h1925, 4'd4,  20, 1'b0, 3'd0};
    vecs[3] = '{"len0",      32'h8421_8421, 16'h1919, 4'd0,   4, 1'b0, 3'd0};
    vecs[4] = '{"len15",     32'h8421_8421, 16'h1919, 4'd15, 36, 1'b0, 3'd0};
    vecs[5] = '{"zero_code", 32'h8421_8480, 16'h1910, 4'd2,  12, 1'b0, 3'd0};
    vecs[6] = '{"len1_bad",  32'h8421_8421, 16'h1918, 4'd1,   8, 1'b1, 3'd0};
    vecs[7] = '{"rsvd_exp6", 32'h8421_8421, 16'h7919, 4'd8,  36, 1'b1, 3'd6};

    srst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_din = '0; prog_exp = '0;
    len = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset err_idx", 32'(err_idx), 32'd0);
    checkOutput("reset det_din", 32'(det_din), 32'd0);
    checkOutput("reset det_srst", 32'(det_srst), 32'd0);
    srst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      program_ram(vecs[v].dins, vecs[v].exps);
      applyStimulus(vecs[v].l, 0, cyc);
      exp_cyc = vecs[v].cycles;
`ifdef SEQ_ERR_HALT_EN
      if (vecs[v].e) exp_cyc = 3 + (int'(vecs[v].idx) + 1) * 4 + 1;
`endif
      checkOutput({vecs[v].name, " done cycle"}, 32'(cyc), 32'(exp_cyc));
      checkOutput({vecs[v].name, " err"}, 32'(err), 32'(vecs[v].e));
      checkOutput({vecs[v].name, " err_idx"}, 32'(err_idx), 32'(vecs[v].idx));
      checkOutput({vecs[v].name, " busy after done"}, 32'(post_busy), 32'd0);
      checkOutput({vecs[v].name, " det_din after done"}, 32'(post_din), 32'd0);
    end

    // srst clears the sticky error left by the last table run.
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    checkOutput("srst clears err", 32'(err), 32'd0);
    checkOutput("srst clears err_idx", 32'(err_idx), 32'd0);

    program_ram(32'h8421_8421, 16'h1919);
    applyStimulus(4'd4, 0, cyc);
    check_trace("clean");
    checkOutput("clean trace done cycle", 32'(cyc), 32'd20);

    // start and prog_we pulsed mid-run; then a readback run proves entry 0 was untouched.
    applyStimulus(4'd4, 6, cyc);
    checkOutput("poke done cycle", 32'(cyc), 32'd20);
    checkOutput("poke err", 32'(err), 32'd0);
    applyStimulus(4'd4, 0, cyc);
    checkOutput("readback done cycle", 32'(cyc), 32'd20);
    checkOutput("readback err", 32'(err), 32'd0);

    len   = 4'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    checkOutput("midrun det_din entry2", 32'(det_din), 32'h4);
    checkOutput("midrun busy", 32'(busy), 32'd1);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    checkOutput("post-srst busy", 32'(busy), 32'd0);
    checkOutput("post-srst det_din", 32'(det_din), 32'd0);
    checkOutput("post-srst det_srst", 32'(det_srst), 32'd0);
    checkOutput("post-srst done", 32'(done), 32'd0);
    checkOutput("post-srst err", 32'(err), 32'd0);
    @(negedge clk);
    applyStimulus(4'd4, 0, cyc);
    check_trace("replay");
    checkOutput("replay done cycle", 32'(cyc), 32'd20);
    checkOutput("replay err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
